// File: rtl/hilo_muldiv_ctrl_if.sv
// Signal bundle between the EX stage / external mul-div units and the HI/LO controller.
// The controller uses the slave view; the pipeline side uses the master view.
interface hilo_muldiv_ctrl_if;
  logic        op_valid;
  logic [2:0]  op_type;
  logic [31:0] op_rs;
  logic        flush;
  logic [31:0] mul_hi;
  logic [31:0] mul_lo;
  logic        div_done;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic        div_start;
  logic        div_cancel;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic        stall;
  logic        busy;

  modport master (
    output op_valid, op_type, op_rs, flush, mul_hi, mul_lo, div_done, div_q, div_r,
    input  div_start, div_cancel, hi_we, lo_we, hi_wdata, lo_wdata, stall, busy
  );

  modport slave (
    input  op_valid, op_type, op_rs, flush, mul_hi, mul_lo, div_done, div_q, div_r,
    output div_start, div_cancel, hi_we, lo_we, hi_wdata, lo_wdata, stall, busy
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO write controller: sequences multiply/divide results and MTHI/MTLO moves
// into the HI/LO registers, stalling the front of the pipeline while a result is pending.
module hilo_muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  hilo_muldiv_ctrl_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [3:0]  cnt_next;
  logic        is_div;
  logic        is_div_next;
  logic [31:0] hi_cap;
  logic [31:0] hi_cap_next;
  logic [31:0] lo_cap;
  logic [31:0] lo_cap_next;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign res_hi = is_div ? bus.div_r : bus.mul_hi;
  assign res_lo = is_div ? bus.div_q : bus.mul_lo;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      is_div <= 1'b0;
      hi_cap <= 32'd0;
      lo_cap <= 32'd0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      is_div <= is_div_next;
      hi_cap <= hi_cap_next;
      lo_cap <= lo_cap_next;
    end
  end

  // Outputs stay at their zero defaults while resetn is low.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    is_div_next    = is_div;
    hi_cap_next    = hi_cap;
    lo_cap_next    = lo_cap;
    bus.div_start  = 1'b0;
    bus.div_cancel = 1'b0;
    bus.hi_we      = 1'b0;
    bus.lo_we      = 1'b0;
    bus.hi_wdata   = 32'd0;
    bus.lo_wdata   = 32'd0;
    bus.stall      = 1'b0;
    bus.busy       = 1'b0;

    if (resetn) begin
      bus.busy = (state != IDLE);
      case (state)
        IDLE: begin
          if (bus.op_valid && !bus.flush) begin
            case (bus.op_type)
              3'd0, 3'd1: begin
                bus.stall   = 1'b1;
                state_next  = MUL;
                cnt_next    = MUL_CNT_INIT;
                is_div_next = 1'b0;
              end
              3'd2, 3'd3: begin
                bus.stall     = 1'b1;
                bus.div_start = 1'b1;
                state_next    = DIV;
                is_div_next   = 1'b1;
              end
              3'd4: begin
                bus.hi_we    = 1'b1;
                bus.hi_wdata = bus.op_rs;
              end
              3'd5: begin
                bus.lo_we    = 1'b1;
                bus.lo_wdata = bus.op_rs;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          if (bus.flush) begin
            state_next = IDLE;
          end else begin
            bus.stall = 1'b1;
            if (cnt == 4'd0) begin
              hi_cap_next = res_hi;
              lo_cap_next = res_lo;
              state_next  = DONE;
            end else begin
              cnt_next = cnt - 4'd1;
            end
          end
        end
        DIV: begin
          // Flush wins over a coincident div_done: the result is dropped.
          if (bus.flush) begin
            bus.div_cancel = 1'b1;
            state_next     = IDLE;
          end else begin
            bus.stall = 1'b1;
            if (bus.div_done) begin
              hi_cap_next = res_hi;
              lo_cap_next = res_lo;
              state_next  = DONE;
            end
          end
        end
        DONE: begin
          bus.hi_we    = 1'b1;
          bus.lo_we    = 1'b1;
          bus.hi_wdata = hi_cap;
          bus.lo_wdata = lo_cap;
          state_next   = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: a vector table for single-cycle IDLE behaviour
// plus hand-written multi-cycle sequences for multiply, divide, flush and reset.
module tb_hilo_muldiv_ctrl;

  localparam logic [31:0] GARBAGE = 32'hDEAD_BEEF;

  logic clk;
  logic resetn;
  int   n_compared;
  int   n_mismatched;

  hilo_muldiv_ctrl_if bus ();

  hilo_muldiv_ctrl #(.MUL_LAT(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        busy;
    logic        div_start;
    logic        div_cancel;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
  } exp_t;

  typedef struct packed {
    logic        rstn;
    logic        valid;
    logic [2:0]  op_type;
    logic [31:0] rs;
    logic        flush;
    logic        done;
    exp_t        exp;
  } vec_t;

  function automatic exp_t mk(input logic st, input logic bz, input logic ds, input logic dc,
                              input logic hwe, input logic lwe,
                              input logic [31:0] hd, input logic [31:0] ld);
    exp_t e;
    e.stall      = st;
    e.busy       = bz;
    e.div_start  = ds;
    e.div_cancel = dc;
    e.hi_we      = hwe;
    e.lo_we      = lwe;
    e.hi_wdata   = hd;
    e.lo_wdata   = ld;
    return e;
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag, input exp_t e);
    compare($sformatf("%s.stall", tag),      32'(bus.stall),      32'(e.stall));
    compare($sformatf("%s.busy", tag),       32'(bus.busy),       32'(e.busy));
    compare($sformatf("%s.div_start", tag),  32'(bus.div_start),  32'(e.div_start));
    compare($sformatf("%s.div_cancel", tag), 32'(bus.div_cancel), 32'(e.div_cancel));
    compare($sformatf("%s.hi_we", tag),      32'(bus.hi_we),      32'(e.hi_we));
    compare($sformatf("%s.lo_we", tag),      32'(bus.lo_we),      32'(e.lo_we));
    compare($sformatf("%s.hi_wdata", tag),   bus.hi_wdata,        e.hi_wdata);
    compare($sformatf("%s.lo_wdata", tag),   bus.lo_wdata,        e.lo_wdata);
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic apply_stimulus(input logic rstn, input logic valid, input logic [2:0] op_type,
                                input logic [31:0] rs, input logic flush, input logic done);
    @(negedge clk);
    resetn       = rstn;
    bus.op_valid = valid;
    bus.op_type  = op_type;
    bus.op_rs    = rs;
    bus.flush    = flush;
    bus.div_done = done;
    #1;
  endtask

  task automatic set_data(input logic [31:0] mh, input logic [31:0] ml,
                          input logic [31:0] q, input logic [31:0] r);
    bus.mul_hi = mh;
    bus.mul_lo = ml;
    bus.div_q  = q;
    bus.div_r  = r;
  endtask

  vec_t vecs[9];
  exp_t idle;

  initial begin
    clk          = 1'b0;
    resetn       = 1'b0;
    n_compared   = 0;
    n_mismatched = 0;
    bus.op_valid = 1'b0;
    bus.op_type  = 3'd0;
    bus.op_rs    = 32'd0;
    bus.flush    = 1'b0;
    bus.div_done = 1'b0;
    set_data(GARBAGE, GARBAGE, GARBAGE, GARBAGE);
    idle = mk(0, 0, 0, 0, 0, 0, 32'd0, 32'd0);

    vecs[0] = '{1'b0, 1'b1, 3'd4, 32'hAAAA_AAAA, 1'b0, 1'b0, idle};
    vecs[1] = '{1'b1, 1'b1, 3'd4, 32'h1234_5678, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, 0, 32'h1234_5678, 32'd0)};
    vecs[2] = '{1'b1, 1'b1, 3'd5, 32'hCAFE_BABE, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1, 32'd0, 32'hCAFE_BABE)};
    vecs[3] = '{1'b1, 1'b1, 3'd6, 32'h1111_1111, 1'b0, 1'b0, idle};
    vecs[4] = '{1'b1, 1'b1, 3'd7, 32'h2222_2222, 1'b0, 1'b0, idle};
    vecs[5] = '{1'b1, 1'b1, 3'd4, 32'h3333_3333, 1'b1, 1'b0, idle};
    vecs[6] = '{1'b1, 1'b1, 3'd5, 32'h4444_4444, 1'b1, 1'b0, idle};
    vecs[7] = '{1'b1, 1'b0, 3'd4, 32'h5555_5555, 1'b0, 1'b1, idle};
    vecs[8] = '{1'b1, 1'b1, 3'd2, 32'h6666_6666, 1'b1, 1'b0, idle};

    apply_stimulus(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i].rstn, vecs[i].valid, vecs[i].op_type, vecs[i].rs,
                     vecs[i].flush, vecs[i].done);
      check_output($sformatf("vec%0d", i), vecs[i].exp);
    end

    // MULT, product only valid in cycle 2; op_valid held during stall.
    apply_stimulus(1, 1, 3'd0, 32'd0, 0, 0);
    check_output("mult.c0", mk(1, 0, 0, 0, 0, 0, 32'd0, 32'd0));
    apply_stimulus(1, 1, 3'd0, 32'd0, 0, 0);
    check_output("mult.c1", mk(1, 1, 0, 0, 0, 0, 32'd0, 32'd0));
    apply_stimulus(1, 1, 3'd0, 32'd0, 0, 0);
    set_data(32'hFFFF_FFFF, 32'hFFFF_FFFE, GARBAGE, GARBAGE);
    check_output("mult.c2", mk(1, 1, 0, 0, 0, 0, 32'd0, 32'd0));
    apply_stimulus(1, 0, 3'd0, 32'd0, 0, 0);
    set_data(GARBAGE, GARBAGE, GARBAGE, GARBAGE);
    check_output("mult.c3", mk(0, 1, 0, 0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFE));
    apply_stimulus(1, 0, 3'd0, 32'd0, 0, 0);
    check_output("mult.c4", idle);

    // MULTU with flush landing in DONE: write still completes.
    apply_stimulus(1, 1, 3'd1, 32'd0, 0, 0);
    check_output("multu.c0", mk(1, 0, 0, 0, 0, 0, 32'd0, 32'd0));
    apply_stimulus(1, 1, 3'd1, 32'd0, 0, 0);
    apply_stimulus(1, 1, 3'd1, 32'd0, 0, 0);
    set_data(32'h0000_0001, 32'h8000_0000, GARBAGE, GARBAGE);
    apply_stimulus(1, 0, 3'd0, 32'd0, 1, 0);
    set_data(GARBAGE, GARBAGE, GARBAGE, GARBAGE);
    check_output("multu.done_flush", mk(0, 1, 0, 0, 1, 1, 32'h0000_0001, 32'h8000_0000));
    apply_stimulus(1, 0, 3'd0, 32'd0, 0, 0);
    check_output("multu.after", idle);

    // DIVU with div_done five cycles after div_start.
    apply_stimulus(1, 1, 3'd3, 32'd0, 0, 0);
    check_output("divu.c0", mk(1, 0, 1, 0, 0, 0, 32'd0, 32'd0));
    for (int c = 1; c <= 4; c++) begin
      apply_stimulus(1, 1, 3'd3, 32'd0, 0, 0);
      check_output($sformatf("divu.c%0d", c), mk(1, 1, 0, 0, 0, 0, 32'd0, 32'd0));
    end
    apply_stimulus(1, 1, 3'd3, 32'd0, 0, 1);
    set_data(GARBAGE, GARBAGE, 32'd7, 32'd3);
    check_output("divu.c5", mk(1, 1, 0, 0, 0, 0, 32'd0, 32'd0));
    apply_stimulus(1, 0, 3'd0, 32'd0, 0, 0);
    set_data(GARBAGE, GARBAGE, GARBAGE, GARBAGE);
    check_output("divu.c6", mk(0, 1, 0, 0, 1, 1, 32'd3, 32'd7));
    apply_stimulus(1, 0, 3'd0, 32'd0, 0, 0);
    check_output("divu.c7", idle);

    // DIV flushed at cycle 3, then a late div_done.
    apply_stimulus(1, 1, 3'd2, 32'd0, 0, 0);
    check_output("divfl.c0", mk(1, 0, 1, 0, 0, 0, 32'd0, 32'd0));
    apply_stimulus(1, 1, 3'd2, 32'd0, 0, 0);
    apply_stimulus(1, 1, 3'd2, 32'd0, 0, 0);
    check_output("divfl.c2", mk(1, 1, 0, 0, 0, 0, 32'd0, 32'd0));
    apply_stimulus(1, 1, 3'd2, 32'd0, 1, 0);
    check_output("divfl.c3", mk(0, 1, 0, 1, 0, 0, 32'd0, 32'd0));
    apply_stimulus(1, 0, 3'd0, 32'd0, 0, 0);
    check_output("divfl.c4", idle);
    apply_stimulus(1, 0, 3'd0, 32'd0, 0, 1);
    set_data(GARBAGE, GARBAGE, 32'd9, 32'd1);
    check_output("divfl.late", idle);
    apply_stimulus(1, 0, 3'd0, 32'd0, 0, 0);
    check_output("divfl.late2", idle);

    // Flush and div_done in the same cycle.
    apply_stimulus(1, 1, 3'd2, 32'd0, 0, 0);
    apply_stimulus(1, 1, 3'd2, 32'd0, 0, 0);
    apply_stimulus(1, 1, 3'd2, 32'd0, 1, 1);
    set_data(GARBAGE, GARBAGE, 32'd5, 32'd6);
    check_output("divboth.c2", mk(0, 1, 0, 1, 0, 0, 32'd0, 32'd0));
    apply_stimulus(1, 0, 3'd0, 32'd0, 0, 0);
    check_output("divboth.c3", idle);
    apply_stimulus(1, 0, 3'd0, 32'd0, 0, 0);
    check_output("divboth.c4", idle);

    // MULT flushed in MUL.
    apply_stimulus(1, 1, 3'd0, 32'd0, 0, 0);
    apply_stimulus(1, 1, 3'd0, 32'd0, 1, 0);
    check_output("mulfl.c1", mk(0, 1, 0, 0, 0, 0, 32'd0, 32'd0));
    apply_stimulus(1, 0, 3'd0, 32'd0, 0, 0);
    check_output("mulfl.c2", idle);
    apply_stimulus(1, 0, 3'd0, 32'd0, 0, 0);
    check_output("mulfl.c3", idle);

    // Reset mid-MUL, then MTLO right after release.
    apply_stimulus(1, 1, 3'd0, 32'd0, 0, 0);
    apply_stimulus(1, 1, 3'd0, 32'd0, 0, 0);
    check_output("rst.c1", mk(1, 1, 0, 0, 0, 0, 32'd0, 32'd0));
    apply_stimulus(0, 1, 3'd0, 32'd0, 0, 0);
    set_data(32'h1357_9BDF, 32'h2468_ACE0, GARBAGE, GARBAGE);
    check_output("rst.c2", idle);
    apply_stimulus(1, 1, 3'd5, 32'h0000_55AA, 0, 0);
    set_data(GARBAGE, GARBAGE, GARBAGE, GARBAGE);
    check_output("rst.mtlo", mk(0, 0, 0, 0, 0, 1, 32'd0, 32'h0000_55AA));
    apply_stimulus(1, 0, 3'd0, 32'd0, 0, 0);
    check_output("rst.after", idle);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
